serial_bus_arbiter: RTL
=======================

SERIAL_BUS_ARBITER -- requirements
Module: serial_bus_arbiter

Interface
REQ-001 clk4  in  1  single system clock; all state changes on rising edge.
REQ-002 reset4  in  1  asynchronous, active-high reset.
REQ-003 req0, req1  in  1 each  transfer requests; held high by requester until its grant.
REQ-004 data0, data1  in  8 each  byte to transmit for requester 0 / 1.
REQ-005 ack_in  in  1  bus acknowledge bit, sampled during ACK phase.
REQ-006 gnt0, gnt1  out  1 each  grant, high for the whole owned transfer, one-hot or zero.
REQ-007 busy  out  1  high from START through STOP_HI.
REQ-008 done  out  1  one-cycle pulse after transfer completes.
REQ-009 nack  out  1  last sampled acknowledge was high (see REQ-030).
REQ-010 scl, sda  out  1 each  serial clock and data, registered, idle high.

Function
REQ-011 FSM states SHALL be IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI; one state per clk4 cycle.
REQ-012 IDLE: scl=1, sda=1; if req0 or req1 high, arbitrate, latch winner's data into 8-bit shift register, set 3-bit bit counter to 7, go START.
REQ-013 Arbitration SHALL be round-robin: single request wins; with both high, requester not granted last wins; after reset req0 wins a tie.
REQ-014 START: scl=1, sda=0 (start condition); go BIT_LO.
REQ-015 BIT_LO: scl=0, sda=shift[7] (MSB first); go BIT_HI.
REQ-016 BIT_HI: scl=1, sda unchanged; if counter=0 go ACK_LO (or STOP_LO, REQ-031), else shift left, decrement counter, go BIT_LO.
REQ-017 ACK_LO: scl=0, sda=1 (released); go ACK_HI.
REQ-018 ACK_HI: scl=1, sda=1, sample ack_in into nack; go STOP_LO.
REQ-019 STOP_LO: scl=0, sda=0; go STOP_HI.
REQ-020 STOP_HI: scl=1, sda=0; go IDLE where sda rises to 1 (stop condition).
REQ-021 Transfer length START..STOP_HI SHALL be 21 cycles with ACK phase, 19 without.
REQ-022 gnt and busy SHALL be high exactly in START..STOP_HI; done SHALL be high in the first IDLE cycle after STOP_HI only.
REQ-023 Requests arriving while busy SHALL be ignored (no queue); they compete at next IDLE, including the IDLE cycle carrying done (back-to-back transfers, one idle cycle between).
REQ-024 Data inputs SHALL be sampled only at the IDLE->START edge; later changes have no effect.
REQ-025 A request dropped before grant SHALL be lost without side effects.

Reset
REQ-026 reset4 high SHALL immediately force state=IDLE, scl=1, sda=1, gnt0=gnt1=0, busy=0, done=0, nack=0, round-robin pointer to "last granted = 1".
REQ-027 Reset mid-transfer SHALL abort without stop condition and without done pulse; requesters SHALL re-request.
REQ-028 First transfer after reset release SHALL begin at the first rising edge where a request is seen.

Configuration
REQ-029 Macro ACK_CHECK_EN SHALL select the acknowledge phase.
REQ-030 Defined: ACK_LO/ACK_HI present; nack updated at ACK_HI edge, held until next ACK_HI or reset.
REQ-031 Undefined: ACK states removed, BIT_HI with counter=0 goes to STOP_LO, ack_in ignored, nack constant 0; port list unchanged.

Verification
REQ-032 Reset, then req0=1, data0=8'hA5 -> gnt0 next cycle, sda bits 1,0,1,0,0,1,0,1 sampled on scl high, done 21 cycles after grant (19 without macro).
REQ-033 req0=req1=1 held continuously, data0=8'h01, data1=8'h80 -> grants alternate gnt0, gnt1, gnt0, one IDLE cycle (done=1) between transfers.
REQ-034 ack_in=1 during ACK_HI with ACK_CHECK_EN -> nack=1 after that edge; next transfer with ack_in=0 -> nack=0; without macro nack stays 0.
REQ-035 reset4 pulsed during BIT_HI of bit 3 -> same cycle scl=1, sda=1, gnt/busy=0, no done; subsequent req1 tie-break grants req0 first.
REQ-036 data0 changed from 8'hFF to 8'h00 one cycle after gnt0 -> serialized byte remains 8'hFF.

Source files
------------

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: two-requester round-robin arbiter driving a bit-banged
// serial bus (start, 8 data bits MSB first, optional ack, stop).
// Optional feature macro: ACK_CHECK_EN adds the ACK_LO/ACK_HI acknowledge phase
// and the nack status; without it the ack states vanish and nack reads 0.
module serial_bus_arbiter (
  input  logic       clk4,
  input  logic       reset4,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       ack_in,
  output logic       gnt0,
  output logic       gnt1,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic       scl,
  output logic       sda
);

  typedef enum logic [2:0] {
    IDLE, START, BIT_LO, BIT_HI, ACK_LO, ACK_HI, STOP_LO, STOP_HI
  } state_t;

  state_t     state, state_nx;
  logic [7:0] shift, shift_nx;
  logic [2:0] cnt, cnt_nx;
  // owner doubles as the round-robin pointer: it always holds the last winner
  logic       owner, owner_nx;
  logic       win;
  logic       scl_nx, sda_nx, busy_nx, done_nx;

`ifndef ACK_CHECK_EN
  // ack_in has no function when the acknowledge phase is compiled out
  logic unused_ack;
  assign unused_ack = ack_in;
`endif

  // Tie goes to whoever was not granted last; a lone request simply wins
  assign win = (req0 && req1) ? ~owner : req1;

  // State, datapath and registered bus/status outputs
  always_ff @(posedge clk4 or posedge reset4) begin
    if (reset4) begin
      state <= IDLE;
      shift <= 8'h00;
      cnt   <= 3'd0;
      owner <= 1'b1;
      scl   <= 1'b1;
      sda   <= 1'b1;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      nack  <= 1'b0;
    end else begin
      state <= state_nx;
      shift <= shift_nx;
      cnt   <= cnt_nx;
      owner <= owner_nx;
      scl   <= scl_nx;
      sda   <= sda_nx;
      busy  <= busy_nx;
      gnt0  <= busy_nx & ~owner_nx;
      gnt1  <= busy_nx & owner_nx;
      done  <= done_nx;
`ifdef ACK_CHECK_EN
      if (state == ACK_HI) nack <= ack_in;
`else
      nack  <= 1'b0;
`endif
    end
  end

  // Next-state, arbitration and shift/counter update
  always_comb begin
    state_nx = state;
    shift_nx = shift;
    cnt_nx   = cnt;
    owner_nx = owner;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nx = START;
          owner_nx = win;
          shift_nx = win ? data1 : data0;
          cnt_nx   = 3'd7;
        end
      end
      START:  state_nx = BIT_LO;
      BIT_LO: state_nx = BIT_HI;
      BIT_HI: begin
        if (cnt == 3'd0) begin
`ifdef ACK_CHECK_EN
          state_nx = ACK_LO;
`else
          state_nx = STOP_LO;
`endif
        end else begin
          shift_nx = {shift[6:0], 1'b0};
          cnt_nx   = cnt - 3'd1;
          state_nx = BIT_LO;
        end
      end
`ifdef ACK_CHECK_EN
      ACK_LO:  state_nx = ACK_HI;
      ACK_HI:  state_nx = STOP_LO;
`endif
      STOP_LO: state_nx = STOP_HI;
      STOP_HI: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output decode of the upcoming state, so scl/sda leave a flop cleanly
  always_comb begin
    scl_nx  = 1'b1;
    sda_nx  = 1'b1;
    busy_nx = (state_nx != IDLE);
    done_nx = (state == STOP_HI);
    case (state_nx)
      IDLE:    begin scl_nx = 1'b1; sda_nx = 1'b1;        end
      START:   begin scl_nx = 1'b1; sda_nx = 1'b0;        end
      BIT_LO:  begin scl_nx = 1'b0; sda_nx = shift_nx[7]; end
      BIT_HI:  begin scl_nx = 1'b1; sda_nx = shift_nx[7]; end
      ACK_LO:  begin scl_nx = 1'b0; sda_nx = 1'b1;        end
      ACK_HI:  begin scl_nx = 1'b1; sda_nx = 1'b1;        end
      STOP_LO: begin scl_nx = 1'b0; sda_nx = 1'b0;        end
      STOP_HI: begin scl_nx = 1'b1; sda_nx = 1'b0;        end
      default: begin scl_nx = 1'b1; sda_nx = 1'b1;        end
    endcase
  end

endmodule
